// File: rtl/spectrum_bar_renderer_if.sv
// Read port of the frequency-magnitude BRAM as seen by the bar renderer.
// The renderer is the master (drives address/enable); the BRAM side returns data.
interface spectrum_bar_renderer_if #(
    parameter int bin_addr_w = 4,
    parameter int data_w     = 16
);
    logic [bin_addr_w-1:0] bram_r_addr;
    logic                  bram_r_en;
    logic [data_w-1:0]     bram_data;

    modport master (output bram_r_addr, output bram_r_en, input  bram_data);
    modport slave  (input  bram_r_addr, input  bram_r_en, output bram_data);
endinterface

// File: rtl/spectrum_bar_renderer.sv
// Horizontal spectrum bars from the SDFT magnitude BRAM: per-line prefetch in
// horizontal blanking, per-bin peak hold with frame-based decay, registered pixel enables.
module spectrum_peak_cell #(
    parameter int data_w = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              upd,
    input  logic [data_w-1:0] din,
    input  logic              decay_tick,
    output logic [data_w-1:0] peak
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            peak <= '0;
        else if (upd) begin
            if (din >= peak)
                peak <= din;
            else if (decay_tick && peak != '0)
                peak <= peak - data_w'(1);
        end
    end
endmodule

module spectrum_bar_renderer #(
    parameter int freq_bins    = 16,
    parameter int bin_addr_w   = 4,
    parameter int data_w       = 16,
    parameter int bar_height   = 30,
    parameter int h_active     = 640,
    parameter int v_total      = 525,
    parameter int axis_width   = 5,
    parameter int decay_frames = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [9:0]              x_px,
    input  logic [9:0]              y_px,
    input  logic                    activevideo,
    spectrum_bar_renderer_if.master bram,
    output logic                    draw_bar,
    output logic                    draw_peak,
    output logic                    draw_axis
);
    localparam int BIN_W = $clog2(freq_bins + 1);
    localparam int LIB_W = $clog2(bar_height + 1);
    localparam int FC_W  = $clog2(decay_frames + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} fetch_st_t;

    fetch_st_t                          st;
    logic [LIB_W-1:0]                   line_in_bar, lib_nxt;
    logic [BIN_W-1:0]                   bin_idx, bin_nxt;
    logic [FC_W-1:0]                    frame_cnt;
    logic [data_w-1:0]                  bar_value, cur_pk, pk_clip, x_ext;
    logic                               bar_valid, decay_tick, fetch_pt, line0_pt;
    logic [freq_bins-1:0][data_w-1:0]   peak_q;

    assign fetch_pt   = (x_px == 10'(h_active));
    assign line0_pt   = fetch_pt && (y_px == 10'(v_total - 1));
    assign decay_tick = (frame_cnt == FC_W'(decay_frames - 1));
    assign x_ext      = data_w'(x_px);

    // Counter values for the line about to start; only committed at a fetch point.
    always_comb begin
        lib_nxt = line_in_bar + LIB_W'(1);
        bin_nxt = bin_idx;
        if (line0_pt) begin
            lib_nxt = '0;
            bin_nxt = '0;
        end else if (line_in_bar == LIB_W'(bar_height - 1)) begin
            lib_nxt = '0;
            if (bin_idx != BIN_W'(freq_bins))
                bin_nxt = bin_idx + BIN_W'(1);
        end
    end

    // bram_r_addr holds the bin of the bar on screen, so it also selects the peak to draw.
    always_comb begin
        cur_pk = '0;
        for (int i = 0; i < freq_bins; i++)
            if (bram.bram_r_addr == bin_addr_w'(i))
                cur_pk = peak_q[i];
    end

    assign pk_clip = (cur_pk > data_w'(h_active - 1)) ? data_w'(h_active - 1) : cur_pk;

    genvar gi;
    generate
        for (gi = 0; gi < freq_bins; gi++) begin : g_peak
            spectrum_peak_cell #(.data_w(data_w)) u_pk (
                .clk       (clk),
                .reset_n   (reset_n),
                .upd       (st == CAPTURE && bram.bram_r_addr == bin_addr_w'(gi)),
                .din       (bram.bram_data),
                .decay_tick(decay_tick),
                .peak      (peak_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st               <= IDLE;
            line_in_bar      <= '0;
            bin_idx          <= '0;
            frame_cnt        <= '0;
            bar_value        <= '0;
            bar_valid        <= 1'b0;
            bram.bram_r_addr <= '0;
            bram.bram_r_en   <= 1'b0;
            draw_bar         <= 1'b0;
            draw_peak        <= 1'b0;
            draw_axis        <= 1'b0;
        end else begin
            draw_axis      <= activevideo && (x_px < 10'(axis_width));
            draw_bar       <= activevideo && bar_valid && (x_ext < bar_value);
            draw_peak      <= activevideo && bar_valid && (cur_pk != '0) && (x_ext == pk_clip);
            bram.bram_r_en <= 1'b0;
            if (fetch_pt) begin
                line_in_bar <= lib_nxt;
                bin_idx     <= bin_nxt;
                if (line0_pt)
                    frame_cnt <= decay_tick ? '0 : frame_cnt + FC_W'(1);
            end
            case (st)
                IDLE:
                    if (fetch_pt && lib_nxt == '0) begin
                        if (bin_nxt < BIN_W'(freq_bins)) begin
                            st               <= ISSUE;
                            bram.bram_r_addr <= bin_addr_w'(bin_nxt);
                            bram.bram_r_en   <= 1'b1;
                        end else
                            bar_valid <= 1'b0;
                    end
                ISSUE:   st <= WAIT;
                WAIT:    st <= CAPTURE;
                CAPTURE: begin
                    bar_value <= bram.bram_data;
                    bar_valid <= 1'b1;
                    st        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Directed bench: per-line pixel checks from a vector table across frames,
// fetch-pulse placement, peak decay, mid-fetch reset and an 8-bin sweep instance.
module tb_spectrum_bar_renderer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] x_px = '0, y_px = '0;
    logic       activevideo = 1'b0;
    logic       draw_bar, draw_peak, draw_axis;
    logic       d8_bar, d8_peak, d8_axis;
    logic [15:0] mem [16];
    int total = 0, bad = 0;

    logic [9:0] py16 [32], px16 [32], py8 [32], px8 [32];
    int         pa16 [32], pa8 [32];
    int         np16 = 0, np8 = 0;

    always #5 clk = ~clk;

    spectrum_bar_renderer_if #(.bin_addr_w(4), .data_w(16)) bif16 ();
    spectrum_bar_renderer_if #(.bin_addr_w(3), .data_w(16)) bif8 ();

    always @(posedge clk) if (bif16.bram_r_en) bif16.bram_data <= mem[bif16.bram_r_addr];
    always @(posedge clk) if (bif8.bram_r_en)  bif8.bram_data  <= mem[bif8.bram_r_addr];

    spectrum_bar_renderer dut (
        .clk(clk), .reset_n(reset_n), .x_px(x_px), .y_px(y_px), .activevideo(activevideo),
        .bram(bif16), .draw_bar(draw_bar), .draw_peak(draw_peak), .draw_axis(draw_axis)
    );

    spectrum_bar_renderer #(.freq_bins(8), .bin_addr_w(3), .bar_height(60)) dut8 (
        .clk(clk), .reset_n(reset_n), .x_px(x_px), .y_px(y_px), .activevideo(activevideo),
        .bram(bif8), .draw_bar(d8_bar), .draw_peak(d8_peak), .draw_axis(d8_axis)
    );

    typedef struct {
        int frame;
        int y;
        bit av;
        int bar_len;
        int peak_x;
    } vec_t;

    localparam int NV = 19;
    vec_t tv [NV];

    // Present one pixel, then sample at the following negedge (outputs lag inputs by one clk).
    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic av);
        x_px = x; y_px = y; activevideo = av;
        @(posedge clk);
        @(negedge clk);
        if (bif16.bram_r_en) begin
            if (np16 < 32) begin py16[np16] = y; px16[np16] = x; pa16[np16] = int'(bif16.bram_r_addr); end
            np16++;
        end
        if (bif8.bram_r_en) begin
            if (np8 < 32) begin py8[np8] = y; px8[np8] = x; pa8[np8] = int'(bif8.bram_r_addr); end
            np8++;
        end
    endtask

    task automatic fast_line(input int y);
        for (int x = 640; x < 645; x++) step(10'(x), 10'(y), 1'b0);
    endtask

    task automatic full_line(input vec_t v);
        int   bad_x;
        logic a;
        logic [2:0] want, got, w_bad, g_bad;
        bad_x = -1; w_bad = '0; g_bad = '0;
        for (int x = 0; x < 645; x++) begin
            a = v.av && (x < 640);
            step(10'(x), 10'(v.y), a);
            want = {a && x < 5, a && x < v.bar_len, a && x == v.peak_x};
            got  = {draw_axis, draw_bar, draw_peak};
            if (bad_x < 0 && got !== want) begin bad_x = x; w_bad = want; g_bad = got; end
        end
        total++;
        if (bad_x >= 0) begin
            bad++;
            $display("FAIL line f%0d y%0d x=%0d axis/bar/peak got %b want %b",
                     v.frame, v.y, bad_x, g_bad, w_bad);
        end
    endtask

    int ti = 0;
    task automatic run_frame(input int f);
        for (int k = 0; k < 525; k++) begin
            int y;
            y = (k == 0) ? 524 : k - 1;
            if (ti < NV && tv[ti].frame == f && tv[ti].y == y) begin
                full_line(tv[ti]);
                ti++;
            end else
                fast_line(y);
        end
    endtask

    task automatic check_pulses(input string nm, input int n, input int step_lines,
                                input int got_n, input int is8);
        int e;
        total++;
        if (got_n != n) begin
            bad++;
            $display("FAIL %s pulse count got %0d want %0d", nm, got_n, n);
        end
        e = 0;
        for (int k = 0; k < n && k < 32; k++) begin
            int ey;
            ey = (k == 0) ? 524 : step_lines * k - 1;
            if (is8 != 0) begin
                if (int'(py8[k]) != ey || px8[k] != 10'd640 || pa8[k] != k) e++;
            end else begin
                if (int'(py16[k]) != ey || px16[k] != 10'd640 || pa16[k] != k) e++;
            end
        end
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL %s pulse placement bad_pulses=%0d want 0", nm, e);
        end
    endtask

    initial begin
        // frame 0: empty BRAM
        tv[0]  = '{0, 0,   1'b1, 0,   -1};
        tv[1]  = '{0, 15,  1'b1, 0,   -1};
        tv[2]  = '{0, 200, 1'b0, 0,   -1};
        tv[3]  = '{0, 479, 1'b1, 0,   -1};
        // frame 1: bins 0,1,2,15 loaded; line 490 has no bar
        tv[4]  = '{1, 0,   1'b1, 100, 100};
        tv[5]  = '{1, 29,  1'b1, 100, 100};
        tv[6]  = '{1, 30,  1'b1, 640, 639};
        tv[7]  = '{1, 59,  1'b1, 640, 639};
        tv[8]  = '{1, 60,  1'b1, 200, 200};
        tv[9]  = '{1, 479, 1'b1, 300, 300};
        tv[10] = '{1, 490, 1'b1, 0,   -1};
        // frame 2 is the first decay frame; bin 2 now reads 50
        tv[11] = '{2, 0,   1'b1, 100, 100};
        tv[12] = '{2, 60,  1'b1, 50,  199};
        tv[13] = '{2, 89,  1'b1, 50,  199};
        tv[14] = '{3, 60,  1'b1, 50,  199};
        tv[15] = '{6, 60,  1'b1, 50,  198};
        // frame 8 follows the mid-fetch reset in frame 7
        tv[16] = '{8, 0,   1'b1, 100, 100};
        tv[17] = '{8, 30,  1'b1, 640, 639};
        tv[18] = '{8, 60,  1'b1, 50,  50};

        for (int i = 0; i < 16; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        total++;
        if ({draw_bar, draw_peak, draw_axis, bif16.bram_r_en} !== 4'b0 || bif16.bram_r_addr !== 4'd0) begin
            bad++;
            $display("FAIL reset outputs got %b addr %0d want 0000 addr 0",
                     {draw_bar, draw_peak, draw_axis, bif16.bram_r_en}, bif16.bram_r_addr);
        end
        reset_n = 1'b1;

        np16 = 0; np8 = 0;
        run_frame(0);
        check_pulses("bins16", 16, 30, np16, 0);
        check_pulses("bins8", 8, 60, np8, 1);

        mem[0] = 16'd100; mem[1] = 16'd640; mem[2] = 16'd200; mem[15] = 16'd300;
        run_frame(1);
        mem[2] = 16'd50;
        for (int f = 2; f < 7; f++) run_frame(f);

        // frame 7: reset while the bin-1 fetch sits in WAIT
        fast_line(524);
        for (int y = 0; y < 29; y++) fast_line(y);
        step(10'd640, 10'd29, 1'b0);
        step(10'd641, 10'd29, 1'b0);
        total++;
        if (bif16.bram_r_addr !== 4'd1) begin
            bad++;
            $display("FAIL pre-reset addr got %0d want 1", bif16.bram_r_addr);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({draw_bar, draw_peak, draw_axis, bif16.bram_r_en} !== 4'b0 || bif16.bram_r_addr !== 4'd0) begin
            bad++;
            $display("FAIL async reset got %b addr %0d want 0000 addr 0",
                     {draw_bar, draw_peak, draw_axis, bif16.bram_r_en}, bif16.bram_r_addr);
        end
        #1 reset_n = 1'b1;
        step(10'd642, 10'd29, 1'b0);
        step(10'd643, 10'd29, 1'b0);
        step(10'd644, 10'd29, 1'b0);
        for (int y = 30; y < 524; y++) fast_line(y);

        run_frame(8);

        total++;
        if (ti != NV) begin
            bad++;
            $display("FAIL vector table consumed got %0d want %0d", ti, NV);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
